// File: rtl/axi_lite_img_loader_pkg.sv
// Shared definitions for the AXI-Lite image loader.
// Contents: loader FSM state enum, AXI response codes and the err_idx
// value that marks a failure of the final control-register write.
package axi_lite_img_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        CADDR,
        CRESP,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0]  OKAY         = 2'b00;
    localparam logic [1:0]  SLVERR       = 2'b10;
    localparam logic [11:0] ERR_IDX_CTRL = 12'hFFF;

endpackage

// File: rtl/axi_lite_wr_chan.sv
// Single AXI-Lite write transaction engine (AW + W + B).
// Ports:
//   i_clk, i_rstn             clock, synchronous active-low reset
//   i_start, i_addr, i_data   launch one write (accepted only when idle)
//   o_addr_done               AW and W both complete this cycle (comb.)
//   o_bdone, o_bresp          B handshake this cycle and its response
//   o_aw*/i_awready, o_w*/i_wready, i_b*/o_bready   AXI-Lite write channels
module axi_lite_wr_chan #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_data,
    output logic                  o_addr_done,
    output logic                  o_bdone,
    output logic [1:0]            o_bresp,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [31:0]           o_wdata,
    output logic [3:0]            o_wstrb,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready
);

    logic                  r_active;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [31:0]           r_wdata;

    // Each channel counts as finished once its VALID has dropped or it is
    // handshaking right now; the pair may finish together or in any order.
    assign o_addr_done = r_active && (!r_awvalid || i_awready) && (!r_wvalid || i_wready);
    assign o_bdone     = r_bready && i_bvalid;
    assign o_bresp     = i_bresp;

    assign o_awaddr  = r_awaddr;
    assign o_awvalid = r_awvalid;
    assign o_wdata   = r_wdata;
    assign o_wstrb   = 4'hF;
    assign o_wvalid  = r_wvalid;
    assign o_bready  = r_bready;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_active  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
        end else if (i_start && !r_active && !r_bready) begin
            r_active  <= 1'b1;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= i_addr;
            r_wdata   <= i_data;
        end else begin
            if (r_awvalid && i_awready) r_awvalid <= 1'b0;
            if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
            if (o_addr_done) begin
                r_active <= 1'b0;
                r_bready <= 1'b1;
            end
            if (r_bready && i_bvalid) r_bready <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_lite_img_loader.sv
// Loads an image word stream into memory over AXI-Lite, optionally reads it
// back and compares XOR checksums, then writes the CPU-release control word.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN   clock, synchronous active-low reset
//   start, word_cnt             begin a load of word_cnt words
//   img_data/img_valid/img_ready  image word stream (valid/ready)
//   M_AXI_*                     AXI-Lite master (AW, W, B, AR, R)
//   busy, done, err, err_idx    status; err is sticky until reset
module axi_lite_img_loader
    import axi_lite_img_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 14,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 14'h0000,
    parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR  = 14'h3000,
    parameter logic [31:0]           CTRL_RUN   = 32'h0,
    parameter bit                    VERIFY     = 1'b1
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,
    input  logic                  start,
    input  logic [11:0]           word_cnt,
    input  logic [31:0]           img_data,
    input  logic                  img_valid,
    output logic                  img_ready,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [31:0]           M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [31:0]           M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [11:0]           err_idx
);

    state_t                r_state;
    logic [11:0]           r_cnt;
    logic [11:0]           r_idx;
    logic [11:0]           r_acc;     // words taken from the stream so far
    logic                  r_dfull;
    logic [31:0]           r_data;
    logic                  r_issued;  // current write already handed to the channel
    logic [31:0]           r_wsum;
    logic [31:0]           r_rsum;
    logic [11:0]           r_err_idx;
    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_rready;

    logic                  w_img_accept;
    logic                  w_wr_start;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [31:0]           w_wr_data;
    logic                  w_addr_done;
    logic                  w_bdone;
    logic [1:0]            w_bresp;
    logic [11:0]           w_idx_nxt;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [11:0] i_idx);
        return BASE_ADDR + ADDR_WIDTH'({i_idx, 2'b00});
    endfunction

    assign w_idx_nxt    = r_idx + 12'd1;
    assign img_ready    = !r_dfull && (r_state == WADDR || r_state == WRESP) && (r_acc < r_cnt);
    assign w_img_accept = img_valid && img_ready;
    assign w_wr_start   = !r_issued && ((r_state == WADDR && r_dfull) || r_state == CADDR);
    assign w_wr_addr    = (r_state == CADDR) ? CTRL_ADDR : word_addr(r_idx);
    assign w_wr_data    = (r_state == CADDR) ? CTRL_RUN : r_data;

    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_RREADY  = r_rready;
    assign busy    = !(r_state == IDLE || r_state == DONE || r_state == ERR);
    assign done    = (r_state == DONE);
    assign err     = (r_state == ERR);
    assign err_idx = r_err_idx;

    axi_lite_wr_chan #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_chan (
        .i_clk       (M_AXI_ACLK),
        .i_rstn      (M_AXI_ARESETN),
        .i_start     (w_wr_start),
        .i_addr      (w_wr_addr),
        .i_data      (w_wr_data),
        .o_addr_done (w_addr_done),
        .o_bdone     (w_bdone),
        .o_bresp     (w_bresp),
        .o_awaddr    (M_AXI_AWADDR),
        .o_awvalid   (M_AXI_AWVALID),
        .i_awready   (M_AXI_AWREADY),
        .o_wdata     (M_AXI_WDATA),
        .o_wstrb     (M_AXI_WSTRB),
        .o_wvalid    (M_AXI_WVALID),
        .i_wready    (M_AXI_WREADY),
        .i_bresp     (M_AXI_BRESP),
        .i_bvalid    (M_AXI_BVALID),
        .o_bready    (M_AXI_BREADY)
    );

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_dfull   <= 1'b0;
            r_data    <= '0;
            r_issued  <= 1'b0;
            r_wsum    <= '0;
            r_rsum    <= '0;
            r_err_idx <= '0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_rready  <= 1'b0;
        end else begin
            // Stream intake runs alongside the write of the previous word.
            if (w_img_accept) begin
                r_data  <= img_data;
                r_dfull <= 1'b1;
                r_acc   <= r_acc + 12'd1;
            end
            if (w_wr_start) r_issued <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt    <= word_cnt;
                        r_idx    <= '0;
                        r_acc    <= '0;
                        r_dfull  <= 1'b0;
                        r_issued <= 1'b0;
                        r_wsum   <= '0;
                        r_rsum   <= '0;
                        r_state  <= (word_cnt != 12'd0) ? WADDR : CADDR;
                    end
                end
                WADDR: begin
                    if (w_wr_start) begin
                        r_dfull <= 1'b0;
                        r_wsum  <= r_wsum ^ r_data;
                    end
                    if (w_addr_done) begin
                        r_issued <= 1'b0;
                        r_state  <= WRESP;
                    end
                end
                WRESP: begin
                    if (w_bdone) begin
                        if (w_bresp != OKAY) begin
                            r_err_idx <= r_idx;
                            r_state   <= ERR;
                        end else if (w_idx_nxt == r_cnt) begin
                            if (VERIFY) begin
                                r_idx     <= '0;
                                r_arvalid <= 1'b1;
                                r_araddr  <= word_addr(12'd0);
                                r_state   <= RADDR;
                            end else begin
                                r_state <= CADDR;
                            end
                        end else begin
                            r_idx   <= w_idx_nxt;
                            r_state <= WADDR;
                        end
                    end
                end
                RADDR: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (M_AXI_RVALID) begin
                        r_rready <= 1'b0;
                        r_rsum   <= r_rsum ^ M_AXI_RDATA;
                        if (M_AXI_RRESP != OKAY) begin
                            r_err_idx <= r_idx;
                            r_state   <= ERR;
                        end else if (w_idx_nxt == r_cnt) begin
                            // Last word: include it in the sum before comparing.
                            if ((r_rsum ^ M_AXI_RDATA) != r_wsum) begin
                                r_err_idx <= r_cnt;
                                r_state   <= ERR;
                            end else begin
                                r_state <= CADDR;
                            end
                        end else begin
                            r_idx     <= w_idx_nxt;
                            r_arvalid <= 1'b1;
                            r_araddr  <= word_addr(w_idx_nxt);
                            r_state   <= RADDR;
                        end
                    end
                end
                CADDR: begin
                    if (w_addr_done) begin
                        r_issued <= 1'b0;
                        r_state  <= CRESP;
                    end
                end
                CRESP: begin
                    if (w_bdone) begin
                        if (w_bresp != OKAY) begin
                            r_err_idx <= ERR_IDX_CTRL;
                            r_state   <= ERR;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                ERR:     r_state <= ERR;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_img_loader.sv
// Directed self-checking bench for axi_lite_img_loader with a small
// behavioural AXI-Lite slave (memory of 16 words plus the control register).
module tb_axi_lite_img_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [11:0] word_cnt = '0;
    logic [31:0] img_data = '0;
    logic        img_valid = 1'b0;
    logic        img_ready;
    logic [13:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [13:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        busy;
    logic        done;
    logic        err;
    logic [11:0] err_idx;

    int n_chk  = 0;
    int n_pass = 0;

    // slave state and configuration
    logic [31:0] mem [0:15];
    logic [13:0] aw_q[$];
    logic [13:0] aw_log[$];
    logic [31:0] w_q[$];
    logic [1:0]  b_q[$];
    logic [13:0] ar_q[$];
    logic [31:0] img_q[$];
    int          n_ar;
    int          n_b;
    int          ctrl_n;
    logic [31:0] ctrl_data;
    int          w_hold;
    bit          saw_split;
    bit          b_hs, r_hs, img_hs;
    bit          err_en;
    logic [13:0] err_addr;
    bit          cor_en;
    logic [13:0] cor_addr;

    axi_lite_img_loader dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rstn),
        .start         (start),
        .word_cnt      (word_cnt),
        .img_data      (img_data),
        .img_valid     (img_valid),
        .img_ready     (img_ready),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_idx       (err_idx)
    );

    always #5 clk = ~clk;

    // Slave reacts on the falling edge; a VALID/READY pair seen here is the
    // handshake that the next rising edge commits.
    always @(negedge clk) begin
        if (!rstn) begin
            aw_q.delete(); aw_log.delete(); w_q.delete(); b_q.delete();
            ar_q.delete(); img_q.delete();
            n_ar = 0; n_b = 0; ctrl_n = 0; ctrl_data = '0;
            saw_split = 1'b0; b_hs = 1'b0; r_hs = 1'b0; img_hs = 1'b0;
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
            rvalid = 1'b0; img_valid = 1'b0;
        end else begin
            if (b_hs) begin bvalid = 1'b0; b_hs = 1'b0; end
            if (r_hs) begin rvalid = 1'b0; r_hs = 1'b0; end
            if (img_hs) begin void'(img_q.pop_front()); img_hs = 1'b0; end
            // B is offered only for writes paired at an earlier edge
            if (!bvalid && b_q.size() > 0) begin
                bvalid = 1'b1;
                bresp  = b_q.pop_front();
                n_b++;
            end
            if (bvalid && bready) b_hs = 1'b1;
            if (!awvalid && wvalid) saw_split = 1'b1;
            awready = awvalid;
            if (awvalid) begin aw_q.push_back(awaddr); aw_log.push_back(awaddr); end
            wready = wvalid && (w_hold == 0);
            if (wvalid && w_hold > 0) w_hold--;
            if (wvalid && wready) w_q.push_back(wdata);
            while (aw_q.size() > 0 && w_q.size() > 0) begin
                logic [13:0] a;
                logic [31:0] d;
                a = aw_q.pop_front();
                d = w_q.pop_front();
                if (a == 14'h3000) begin ctrl_n++; ctrl_data = d; end
                else mem[a[5:2]] = d;
                b_q.push_back((err_en && a == err_addr) ? 2'b10 : 2'b00);
            end
            if (!rvalid && ar_q.size() > 0) begin
                logic [13:0] a;
                a = ar_q.pop_front();
                rvalid = 1'b1;
                rresp  = 2'b00;
                rdata  = mem[a[5:2]] ^ ((cor_en && a == cor_addr) ? 32'h1 : 32'h0);
            end
            if (rvalid && rready) r_hs = 1'b1;
            arready = arvalid;
            if (arvalid) begin ar_q.push_back(araddr); n_ar++; end
            img_valid = (img_q.size() > 0);
            img_data  = img_valid ? img_q[0] : 32'h0;
            if (img_valid && img_ready) img_hs = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0;
        w_hold = 0; err_en = 1'b0; cor_en = 1'b0; err_addr = '0; cor_addr = '0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic start_load(input logic [11:0] n);
        start = 1'b1; word_cnt = n;
        tick();
        start = 1'b0;
    endtask

    // Waits for done or err; an expired budget counts as a failed check.
    task automatic wait_end(input string tag);
        int k;
        for (k = 0; k < 2000; k++) begin
            if (done || err) break;
            tick();
        end
        chk({tag, "_finished"}, {31'd0, done | err}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        do_reset();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_err_idx", {20'd0, err_idx}, 0);
        chk("rst_img_ready", {31'd0, img_ready}, 0);
        chk("rst_valids", {28'd0, awvalid, wvalid, arvalid, bready | rready}, 0);
        chk("rst_addr", {18'd0, awaddr | araddr}, 0);
        chk("rst_wdata", wdata, 0);

        // basic 4-word load, zero-wait slave
        img_q.push_back(32'h1); img_q.push_back(32'h2);
        img_q.push_back(32'h3); img_q.push_back(32'h4);
        start_load(12'd4);
        chk("t1_busy", {31'd0, busy}, 1);
        wait_end("t1");
        chk("t1_done", {31'd0, done}, 1);
        chk("t1_err", {31'd0, err}, 0);
        tick();
        chk("t1_done_pulse", {31'd0, done}, 0);
        chk("t1_idle_busy", {31'd0, busy}, 0);
        chk("t1_aw_n", aw_log.size(), 5);
        if (aw_log.size() == 5) begin
            chk("t1_aw0", {18'd0, aw_log[0]}, 32'h0);
            chk("t1_aw1", {18'd0, aw_log[1]}, 32'h4);
            chk("t1_aw2", {18'd0, aw_log[2]}, 32'h8);
            chk("t1_aw3", {18'd0, aw_log[3]}, 32'hC);
            chk("t1_aw_ctrl", {18'd0, aw_log[4]}, 32'h3000);
        end
        chk("t1_mem3", mem[3], 32'h4);
        chk("t1_reads", n_ar, 4);
        chk("t1_ctrl_n", ctrl_n, 1);
        chk("t1_ctrl_data", ctrl_data, 32'h0);
        chk("t1_wstrb", {28'd0, wstrb}, 32'hF);

        // W delayed on word 0
        do_reset();
        w_hold = 3;
        img_q.push_back(32'hA0); img_q.push_back(32'hB1);
        img_q.push_back(32'hC2); img_q.push_back(32'hD3);
        start_load(12'd4);
        wait_end("t2");
        chk("t2_done", {31'd0, done}, 1);
        chk("t2_split", {31'd0, saw_split}, 1);
        chk("t2_b_n", n_b, 5);
        chk("t2_aw_n", aw_log.size(), 5);
        chk("t2_mem0", mem[0], 32'hA0);
        chk("t2_mem1", mem[1], 32'hB1);
        chk("t2_mem2", mem[2], 32'hC2);
        chk("t2_mem3", mem[3], 32'hD3);

        // SLVERR on word 2
        do_reset();
        err_en = 1'b1; err_addr = 14'h8;
        img_q.push_back(32'h11); img_q.push_back(32'h22);
        img_q.push_back(32'h33); img_q.push_back(32'h44);
        start_load(12'd4);
        wait_end("t3");
        chk("t3_err", {31'd0, err}, 1);
        chk("t3_err_idx", {20'd0, err_idx}, 2);
        chk("t3_busy", {31'd0, busy}, 0);
        begin
            int rdy_n;
            rdy_n = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (img_ready) rdy_n++;
            end
            chk("t3_img_ready_low", rdy_n, 0);
        end
        start_load(12'd2);
        repeat (5) tick();
        chk("t3_err_sticky", {31'd0, err}, 1);
        chk("t3_busy_after_start", {31'd0, busy}, 0);
        chk("t3_aw_n", aw_log.size(), 3);
        chk("t3_reads", n_ar, 0);

        // corrupted readback of word 1
        do_reset();
        cor_en = 1'b1; cor_addr = 14'h4;
        img_q.push_back(32'h1234_0000); img_q.push_back(32'h1234_0001);
        img_q.push_back(32'h1234_0002); img_q.push_back(32'h1234_0003);
        start_load(12'd4);
        wait_end("t4");
        chk("t4_err", {31'd0, err}, 1);
        chk("t4_err_idx", {20'd0, err_idx}, 4);
        chk("t4_reads", n_ar, 4);
        chk("t4_no_ctrl", ctrl_n, 0);
        chk("t4_aw_n", aw_log.size(), 4);

        // word_cnt = 0
        do_reset();
        start_load(12'd0);
        wait_end("t5");
        chk("t5_done", {31'd0, done}, 1);
        chk("t5_aw_n", aw_log.size(), 1);
        if (aw_log.size() == 1) chk("t5_aw_ctrl", {18'd0, aw_log[0]}, 32'h3000);
        chk("t5_reads", n_ar, 0);
        chk("t5_ctrl_n", ctrl_n, 1);

        // reset while WVALID high on word 1
        do_reset();
        img_q.push_back(32'h5); img_q.push_back(32'h6);
        img_q.push_back(32'h7); img_q.push_back(32'h8);
        start_load(12'd4);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (wvalid && awaddr == 14'h4) begin seen = 1'b1; break; end
                tick();
            end
            chk("t6_w1_seen", {31'd0, seen}, 1);
        end
        rstn = 1'b0;
        tick();
        chk("t6_valids", {29'd0, awvalid, wvalid, arvalid}, 0);
        chk("t6_busy", {31'd0, busy}, 0);
        rstn = 1'b1;
        tick();
        chk("t6_idle_busy", {31'd0, busy}, 0);
        img_q.push_back(32'h77); img_q.push_back(32'h88);
        start_load(12'd2);
        wait_end("t6");
        chk("t6_done", {31'd0, done}, 1);
        if (aw_log.size() >= 2) begin
            chk("t6_aw0", {18'd0, aw_log[0]}, 32'h0);
            chk("t6_aw1", {18'd0, aw_log[1]}, 32'h4);
        end else begin
            chk("t6_aw_n", aw_log.size(), 3);
        end
        chk("t6_mem0", mem[0], 32'h77);
        chk("t6_mem1", mem[1], 32'h88);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
